// File: rtl/reaction_sequencer.sv
// reaction_sequencer
// Runs one reaction-time trial. A pseudo-random pre-stimulus delay comes first.
// The lamp then turns on and the response is timed in 1 ms ticks. The result is
// written back to an external register file with read-modify-write cycles:
// R0 = last time, R1 = best time, R2 = trial count, R3 = fault count.
// Pressing before the lamp turns on increments the fault count and parks the
// sequencer in FAULT until the next START.
// Optional build macro REACTION_TIMEOUT_EN ends TIMING automatically once the
// timer equals TIMEOUT_MS. Without it, only REACT leaves TIMING and the timer
// saturates at 8191.
module reaction_sequencer #(
    parameter int DELAY_BASE = 1000,
    parameter int TIMEOUT_MS = 1999
) (
    input  logic        CLK,
    input  logic        CLRN,
    input  logic        START,
    input  logic        REACT,
    input  logic        TICK,
    input  logic [12:0] DATAP,
    output logic [2:0]  RP,
    output logic [2:0]  WA,
    output logic [12:0] LD_DATA,
    output logic        WR,
    output logic        LED,
    output logic        BUSY,
    output logic        DONE,
    output logic        TOO_SOON
);

    localparam logic [12:0] LFSR_SEED    = 13'h1ACE;
    localparam logic [12:0] TIMER_MAX    = 13'h1FFF;
    localparam logic [12:0] TIMEOUT_V    = 13'(TIMEOUT_MS);
    localparam logic [15:0] DELAY_BASE_V = 16'(DELAY_BASE);

`ifdef REACTION_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        DELAY   = 4'd1,
        TIMING  = 4'd2,
        WB_LAST = 4'd3,
        RD_BEST = 4'd4,
        WB_BEST = 4'd5,
        RD_CNT  = 4'd6,
        WB_CNT  = 4'd7,
        FLT_RD  = 4'd8,
        FLT_WB  = 4'd9,
        FAULT   = 4'd10
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [12:0] lfsr;
    logic        lfsr_fb;
    logic [12:0] timer;
    logic [12:0] timer_next;
    logic [15:0] delay_cnt;
    logic [15:0] delay_next;
    logic [12:0] capture;
    logic [12:0] capture_next;
    logic        timeout_hit;
    logic        new_best;

    assign lfsr_fb     = lfsr[12] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0];
    assign timeout_hit = TIMEOUT_ON && (timer == TIMEOUT_V);
    assign new_best    = (capture == 13'd0) || (timer < capture);

    // Free-running Fibonacci LFSR that seeds the pre-stimulus delay.
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[11:0], lfsr_fb};
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers: reaction timer, delay countdown and read capture.
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            timer     <= 13'd0;
            delay_cnt <= 16'd0;
            capture   <= 13'd0;
        end else begin
            timer     <= timer_next;
            delay_cnt <= delay_next;
            capture   <= capture_next;
        end
    end

    // Next-state, datapath updates and Moore output decode.
    always_comb begin
        next_state   = state;
        timer_next   = timer;
        delay_next   = delay_cnt;
        capture_next = capture;
        RP           = 3'd0;
        WA           = 3'd0;
        LD_DATA      = 13'd0;
        WR           = 1'b0;
        LED          = 1'b0;
        BUSY         = 1'b1;
        DONE         = 1'b0;
        TOO_SOON     = 1'b0;

        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    next_state = DELAY;
                    delay_next = DELAY_BASE_V + {5'd0, lfsr[10:0]};
                    timer_next = 13'd0;
                end
            end

            FAULT: begin
                BUSY     = 1'b0;
                TOO_SOON = 1'b1;
                if (START) begin
                    next_state = DELAY;
                    delay_next = DELAY_BASE_V + {5'd0, lfsr[10:0]};
                    timer_next = 13'd0;
                end
            end

            DELAY: begin
                if (REACT) begin
                    next_state = FLT_RD;
                end else if (delay_cnt == 16'd0) begin
                    next_state = TIMING;
                end else if (TICK) begin
                    delay_next = delay_cnt - 16'd1;
                    if (delay_cnt == 16'd1) begin
                        next_state = TIMING;
                    end
                end
            end

            TIMING: begin
                LED = 1'b1;
                if (REACT || timeout_hit) begin
                    next_state = WB_LAST;
                end else if (TICK && (timer != TIMER_MAX)) begin
                    timer_next = timer + 13'd1;
                end
            end

            WB_LAST: begin
                WA         = 3'd0;
                LD_DATA    = timer;
                WR         = 1'b1;
                next_state = RD_BEST;
            end

            RD_BEST: begin
                RP           = 3'd1;
                capture_next = DATAP;
                next_state   = WB_BEST;
            end

            WB_BEST: begin
                if (new_best) begin
                    WA      = 3'd1;
                    LD_DATA = timer;
                    WR      = 1'b1;
                end
                next_state = RD_CNT;
            end

            RD_CNT: begin
                RP           = 3'd2;
                capture_next = DATAP;
                next_state   = WB_CNT;
            end

            WB_CNT: begin
                WA         = 3'd2;
                LD_DATA    = capture + 13'd1;
                WR         = 1'b1;
                DONE       = 1'b1;
                next_state = IDLE;
            end

            FLT_RD: begin
                RP           = 3'd3;
                capture_next = DATAP;
                next_state   = FLT_WB;
            end

            FLT_WB: begin
                WA         = 3'd3;
                LD_DATA    = capture + 13'd1;
                WR         = 1'b1;
                next_state = FAULT;
            end

            default: begin
                BUSY       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reaction_sequencer.sv
// tb_reaction_sequencer
// Drives directed trials into reaction_sequencer with a small register file
// attached. The outputs are checked every cycle against a behavioural model
// built from trial phases and a schedule of register-file bus operations.
// Hand-computed register and timing values are also checked.
`timescale 1ns/1ps
module tb_reaction_sequencer;

    localparam int DELAY_BASE = 1000;
    localparam int TIMEOUT_MS = 1999;

    logic        CLK = 1'b0;
    logic        CLRN;
    logic        START;
    logic        REACT;
    logic        TICK;
    logic [12:0] DATAP;
    logic [2:0]  RP;
    logic [2:0]  WA;
    logic [12:0] LD_DATA;
    logic        WR;
    logic        LED;
    logic        BUSY;
    logic        DONE;
    logic        TOO_SOON;

    int n_compared   = 0;
    int n_mismatched = 0;
    int done_count   = 0;
    int wr_count     = 0;
    bit led_seen     = 0;

    always #5 CLK = ~CLK;

    reaction_sequencer #(
        .DELAY_BASE(DELAY_BASE),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .CLK      (CLK),
        .CLRN     (CLRN),
        .START    (START),
        .REACT    (REACT),
        .TICK     (TICK),
        .DATAP    (DATAP),
        .RP       (RP),
        .WA       (WA),
        .LD_DATA  (LD_DATA),
        .WR       (WR),
        .LED      (LED),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .TOO_SOON (TOO_SOON)
    );

    // External register file sharing the reset net, with a bench preload port.
    logic [12:0] rf [8];
    logic        pre_en   = 1'b0;
    logic [2:0]  pre_addr = 3'd0;
    logic [12:0] pre_data = 13'd0;

    assign DATAP = rf[RP];

    always @(posedge CLK) begin
        if (!CLRN) begin
            for (int i = 0; i < 8; i++) rf[i] <= 13'd0;
        end else if (WR) begin
            rf[WA] <= LD_DATA;
        end else if (pre_en) begin
            rf[pre_addr] <= pre_data;
        end
    end

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_DELAY, M_TIMING, M_FAULT} mode_t;

    mode_t       m_mode  = M_IDLE;
    mode_t       m_after = M_IDLE;
    bit          m_valid = 0;
    logic [12:0] m_lfsr  = 13'h1ACE;
    int          m_ticks_needed = 0;
    int          m_ticks_seen   = 0;
    int          m_timer        = 0;
    int          m_regs [8];
    logic [20:0] m_sched [$];

`ifdef REACTION_TIMEOUT_EN
    localparam bit M_TIMEOUT = 1'b1;
`else
    localparam bit M_TIMEOUT = 1'b0;
`endif

    function automatic logic [12:0] lfsr_step(input logic [12:0] v);
        return {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
    endfunction

    // One bus cycle: {DONE, WR, WA, LD_DATA, RP}
    function automatic logic [20:0] op(input bit done, input bit wr, input int wa,
                                       input int data, input int rp);
        return {done, wr, 3'(wa), 13'(data), 3'(rp)};
    endfunction

    task automatic schedule_trial();
        int  best;
        int  cnt;
        bit  better;
        best   = m_regs[1];
        cnt    = m_regs[2];
        better = (best == 0) || (m_timer < best);
        m_sched.push_back(op(0, 1, 0, m_timer, 0));
        m_sched.push_back(op(0, 0, 0, 0, 1));
        m_sched.push_back(better ? op(0, 1, 1, m_timer, 0) : op(0, 0, 0, 0, 0));
        m_sched.push_back(op(0, 0, 0, 0, 2));
        m_sched.push_back(op(1, 1, 2, (cnt + 1) % 8192, 0));
        m_regs[0] = m_timer;
        if (better) m_regs[1] = m_timer;
        m_regs[2] = (cnt + 1) % 8192;
        m_after   = M_IDLE;
    endtask

    task automatic schedule_fault();
        m_sched.push_back(op(0, 0, 0, 0, 3));
        m_sched.push_back(op(0, 1, 3, (m_regs[3] + 1) % 8192, 0));
        m_regs[3] = (m_regs[3] + 1) % 8192;
        m_after   = M_FAULT;
    endtask

    // Model advances on each rising edge from the inputs presented that cycle.
    always @(posedge CLK) begin
        if (!CLRN) begin
            m_valid = 1;
            m_mode  = M_IDLE;
            m_sched.delete();
            m_lfsr  = 13'h1ACE;
            m_timer = 0;
            for (int i = 0; i < 8; i++) m_regs[i] = 0;
        end else begin
            if (m_sched.size() != 0) begin
                void'(m_sched.pop_front());
                if (m_sched.size() == 0) m_mode = m_after;
            end else begin
                case (m_mode)
                    M_IDLE, M_FAULT: begin
                        if (START) begin
                            m_mode         = M_DELAY;
                            m_ticks_needed = DELAY_BASE + int'(m_lfsr & 13'h7FF);
                            m_ticks_seen   = 0;
                            m_timer        = 0;
                        end
                    end
                    M_DELAY: begin
                        if (REACT) begin
                            schedule_fault();
                        end else begin
                            if (TICK) m_ticks_seen++;
                            if (m_ticks_seen >= m_ticks_needed) m_mode = M_TIMING;
                        end
                    end
                    M_TIMING: begin
                        if (REACT || (M_TIMEOUT && m_timer == TIMEOUT_MS)) begin
                            schedule_trial();
                        end else if (TICK) begin
                            m_timer = (m_timer < 8191) ? m_timer + 1 : 8191;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
            if (pre_en) m_regs[pre_addr] = int'(pre_data);
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    // {LED, BUSY, TOO_SOON, DONE, WR, WA, LD_DATA, RP}
    function automatic logic [23:0] expected_outputs();
        if (m_sched.size() != 0) return {3'b010, m_sched[0]};
        case (m_mode)
            M_FAULT:  return {3'b001, 21'd0};
            M_DELAY:  return {3'b010, 21'd0};
            M_TIMING: return {3'b110, 21'd0};
            default:  return 24'd0;
        endcase
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (m_valid) begin
            logic [23:0] exp_v;
            logic [23:0] act_v;
            exp_v = expected_outputs();
            act_v = {LED, BUSY, TOO_SOON, DONE, WR, WA, LD_DATA, RP};
            n_compared++;
            if (act_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL cycle_outputs @%0t actual=%h required=%h (LED,BUSY,TOO_SOON,DONE,WR,WA,LD_DATA,RP)",
                         $time, act_v, exp_v);
            end
            if (DONE === 1'b1) done_count++;
            if (WR === 1'b1) wr_count++;
            if (LED === 1'b1) led_seen = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input logic start, input logic react, input logic tick);
        START = start;
        REACT = react;
        TICK  = tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_led(input int period, input int max_cycles, output int ticks);
        ticks = 0;
        for (int c = 0; c < max_cycles && LED !== 1'b1; c++) begin
            logic t;
            t = ((c % period) == period - 1);
            applyStimulus(1'b0, 1'b0, t);
            if (t) ticks++;
        end
        if (LED !== 1'b1) checkOutput("led_rise_timeout", 32'(LED), 32'd1);
    endtask

    task automatic run_ticks(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < period - 1; k++) applyStimulus(1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ticks;
        int done_base;
        int wr_base;

        CLRN  = 1'b0;
        START = 1'b0;
        REACT = 1'b0;
        TICK  = 1'b0;
        idle_cycles(2);
        checkOutput("reset_outputs", 32'({LED, BUSY, DONE, TOO_SOON, WR, WA, LD_DATA, RP}), 32'd0);

        // Trial 1: START on the first edge after reset, LFSR still at seed.
        CLRN = 1'b1;
        done_base = done_count;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("busy_after_start", 32'(BUSY), 32'd1);
        wait_led(10, 40000, ticks);
        checkOutput("delay_ticks_trial1", 32'(ticks), 32'd1718);
        run_ticks(250, 10);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle_cycles(6);
        checkOutput("R0_trial1", 32'(rf[0]), 32'd250);
        checkOutput("R1_trial1", 32'(rf[1]), 32'd250);
        checkOutput("R2_trial1", 32'(rf[2]), 32'd1);
        checkOutput("done_pulses_trial1", 32'(done_count - done_base), 32'd1);
        checkOutput("idle_after_trial1", 32'(BUSY), 32'd0);

        // Trial 2: slower response must not replace the best time.
        done_base = done_count;
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_led(1, 3200, ticks);
        checkOutput("delay_ticks_trial2", 32'(ticks), 32'(m_ticks_needed));
        run_ticks(300, 1);
        wr_base = wr_count;
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle_cycles(6);
        checkOutput("R0_trial2", 32'(rf[0]), 32'd300);
        checkOutput("R1_trial2", 32'(rf[1]), 32'd250);
        checkOutput("R2_trial2", 32'(rf[2]), 32'd2);
        checkOutput("wr_pulses_trial2", 32'(wr_count - wr_base), 32'd2);
        checkOutput("done_pulses_trial2", 32'(done_count - done_base), 32'd1);

        // Early press lands in FAULT without lighting the lamp.
        led_seen = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        run_ticks(5, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle_cycles(3);
        checkOutput("too_soon_fault", 32'(TOO_SOON), 32'd1);
        checkOutput("busy_in_fault", 32'(BUSY), 32'd0);
        checkOutput("R3_fault1", 32'(rf[3]), 32'd1);
        checkOutput("R0_kept_on_fault", 32'(rf[0]), 32'd300);
        checkOutput("led_never_in_fault", 32'(led_seen), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("restart_from_fault_busy", 32'(BUSY), 32'd1);
        checkOutput("restart_from_fault_too_soon", 32'(TOO_SOON), 32'd0);

        // Second early press, then preload the trial count to its maximum.
        run_ticks(2, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle_cycles(3);
        checkOutput("R3_fault2", 32'(rf[3]), 32'd2);
        pre_en   = 1'b1;
        pre_addr = 3'd2;
        pre_data = 13'd8191;
        idle_cycles(1);
        pre_en   = 1'b0;

        // Trial count wraps from 8191 to 0; a faster time becomes the best.
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_led(1, 3200, ticks);
        run_ticks(100, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle_cycles(6);
        checkOutput("R2_wrap", 32'(rf[2]), 32'd0);
        checkOutput("R0_trial3", 32'(rf[0]), 32'd100);
        checkOutput("R1_improved", 32'(rf[1]), 32'd100);

        // Reset in the middle of TIMING aborts with no write.
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_led(1, 3200, ticks);
        run_ticks(20, 1);
        wr_base = wr_count;
        CLRN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        CLRN = 1'b1;
        checkOutput("led_after_mid_reset", 32'(LED), 32'd0);
        checkOutput("busy_after_mid_reset", 32'(BUSY), 32'd0);
        idle_cycles(2);
        checkOutput("no_wr_on_mid_reset", 32'(wr_count - wr_base), 32'd0);
        checkOutput("R0_cleared_by_reset", 32'(rf[0]), 32'd0);

        // Long wait in TIMING: timeout build ends the trial, default saturates.
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_led(1, 3200, ticks);
`ifdef REACTION_TIMEOUT_EN
        done_base = done_count;
        for (int c = 0; c < 2200 && done_count == done_base; c++) applyStimulus(1'b0, 1'b0, 1'b1);
        idle_cycles(2);
        checkOutput("timeout_done", 32'(done_count - done_base), 32'd1);
        checkOutput("R0_timeout", 32'(rf[0]), 32'(TIMEOUT_MS));
        checkOutput("idle_after_timeout", 32'(BUSY), 32'd0);
`else
        run_ticks(9000, 1);
        checkOutput("busy_saturated", 32'(BUSY), 32'd1);
        checkOutput("led_saturated", 32'(LED), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle_cycles(6);
        checkOutput("R0_saturated", 32'(rf[0]), 32'd8191);
        checkOutput("R1_saturated", 32'(rf[1]), 32'd8191);
        checkOutput("R2_after_reset_trial", 32'(rf[2]), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
